// File: rtl/pfr_spi_mux.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : pfr_spi_mux
// Purpose  : N-host SPI flash ownership multiplexer. Routes one of N_HOST SPI
//            masters to a single shared flash. Ownership only changes between
//            transactions, with a guard interval of forced-idle flash pins
//            between owners. The owner's opcode is snooped on a CLK-
//            oversampled copy of its bus, and program/erase opcodes can be
//            aborted by forcing the flash chip select high during the
//            address phase.
// Ports    : clk, rst        system clock, asynchronous active-high reset
//            hcsn/hsck/hmosi host SPI inputs (one bit per host)
//            hmiso           host MISO (owner gets fmiso, others idle high)
//            fcsn/fsck/fmosi flash-side SPI outputs, fmiso flash data in
//            sel_req/sel_vld ownership request index and strobe
//            block_en        enables aborting of blocked opcodes
//            owner, sw_busy  current owner, switch pending or in guard
//            cmd_byte/cmd_stb last snooped opcode and its update pulse
//            viol            pulse when a transaction is aborted
// Revision : 1.0 - initial release
// ============================================================================
module pfr_spi_mux #(
  parameter int N_HOST      = 2,
  parameter int OWN_W       = 1,
  parameter int RESET_OWNER = 0,
  parameter int GUARD_CYC   = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_HOST-1:0] hcsn,
  input  logic [N_HOST-1:0] hsck,
  input  logic [N_HOST-1:0] hmosi,
  output logic [N_HOST-1:0] hmiso,
  output logic              fcsn,
  output logic              fsck,
  output logic              fmosi,
  input  logic              fmiso,
  input  logic [OWN_W-1:0]  sel_req,
  input  logic              sel_vld,
  input  logic              block_en,
  output logic [OWN_W-1:0]  owner,
  output logic              sw_busy,
  output logic [7:0]        cmd_byte,
  output logic              cmd_stb,
  output logic              viol
);

  // --------------------------------------------------------------------------
  // Elaboration-time parameter sanity
  // --------------------------------------------------------------------------
  if (N_HOST < 2 || N_HOST > 8) begin : g_chk_nhost
    $error("pfr_spi_mux: N_HOST out of range");
  end
  if ((1 << OWN_W) < N_HOST) begin : g_chk_ownw
    $error("pfr_spi_mux: OWN_W too narrow for N_HOST");
  end
  if (GUARD_CYC < 1 || GUARD_CYC > 255) begin : g_chk_guard
    $error("pfr_spi_mux: GUARD_CYC out of range");
  end
  if (SYNC_STAGES < 2 || SYNC_STAGES > 3) begin : g_chk_sync
    $error("pfr_spi_mux: SYNC_STAGES out of range");
  end
  if (RESET_OWNER < 0 || RESET_OWNER >= N_HOST) begin : g_chk_rstown
    $error("pfr_spi_mux: RESET_OWNER out of range");
  end

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [1:0]       S_OWNED  = 2'd0;
  localparam logic [1:0]       S_DRAIN  = 2'd1;
  localparam logic [1:0]       S_GUARD  = 2'd2;
  localparam logic [7:0]       C_GLOAD  = 8'(GUARD_CYC);
  localparam logic [OWN_W-1:0] C_ROWNER = OWN_W'(RESET_OWNER);

  // --------------------------------------------------------------------------
  // Registers and wires
  // --------------------------------------------------------------------------
  logic [1:0]        r_state;
  logic [7:0]        r_gcnt;
  logic [OWN_W-1:0]  r_owner;
  logic [OWN_W-1:0]  r_pend;
  logic              r_pend_vld;

  logic [N_HOST-1:0] r_csn_sync  [SYNC_STAGES];
  logic [N_HOST-1:0] r_sck_sync  [SYNC_STAGES];
  logic [N_HOST-1:0] r_mosi_sync [SYNC_STAGES];

  logic              r_csn_d;
  logic              r_sck_d;
  logic [3:0]        r_bitcnt;
  logic [6:0]        r_shift;
  logic [7:0]        r_cmd_byte;
  logic              r_cmd_stb;
  logic              r_viol;
  logic              r_force_cs;

  logic              w_raw_csn;
  logic              w_raw_sck;
  logic              w_raw_mosi;
  logic              w_own_csn;
  logic              w_own_sck;
  logic              w_own_mosi;
  logic              w_sel_ok;
  logic [OWN_W-1:0]  w_pend_now;
  logic              w_pend_vld_now;
  logic              w_sck_rise;
  logic              w_csn_edge;

  function automatic logic f_blocked(input logic [7:0] op);
    logic hit;
    case (op)
      8'h02, 8'h20, 8'h52, 8'hD8: hit = 1'b1;
      default:                    hit = 1'b0;
    endcase
    return hit;
  endfunction

  // --------------------------------------------------------------------------
  // Input synchronisers. Every host is synchronised (not just the owner) so
  // that a freshly selected owner already has settled history in the chain.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        r_csn_sync[k]  <= '1;
        r_sck_sync[k]  <= '0;
        r_mosi_sync[k] <= '0;
      end
    end else begin
      r_csn_sync[0]  <= hcsn;
      r_sck_sync[0]  <= hsck;
      r_mosi_sync[0] <= hmosi;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        r_csn_sync[k]  <= r_csn_sync[k-1];
        r_sck_sync[k]  <= r_sck_sync[k-1];
        r_mosi_sync[k] <= r_mosi_sync[k-1];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Owner selection: raw pins for the datapath, synchronised copy for the
  // snooper and drain logic. Non-owner MISO idles high.
  // --------------------------------------------------------------------------
  always_comb begin
    w_raw_csn  = 1'b1;
    w_raw_sck  = 1'b0;
    w_raw_mosi = 1'b0;
    w_own_csn  = 1'b1;
    w_own_sck  = 1'b0;
    w_own_mosi = 1'b0;
    hmiso      = '1;
    for (int i = 0; i < N_HOST; i++) begin
      if (r_owner == OWN_W'(i)) begin
        w_raw_csn  = hcsn[i];
        w_raw_sck  = hsck[i];
        w_raw_mosi = hmosi[i];
        w_own_csn  = r_csn_sync[SYNC_STAGES-1][i];
        w_own_sck  = r_sck_sync[SYNC_STAGES-1][i];
        w_own_mosi = r_mosi_sync[SYNC_STAGES-1][i];
        hmiso[i]   = fmiso;
      end
    end
  end

  // Flash pins are parked idle for the whole guard interval.
  always_comb begin
    if (r_state == S_GUARD) begin
      fcsn  = 1'b1;
      fsck  = 1'b0;
      fmosi = 1'b0;
    end else begin
      fcsn  = w_raw_csn | r_force_cs;
      fsck  = w_raw_sck;
      fmosi = w_raw_mosi;
    end
  end

  // --------------------------------------------------------------------------
  // Ownership FSM
  // --------------------------------------------------------------------------
  assign w_sel_ok       = sel_vld && (32'(sel_req) < N_HOST);
  // A request arriving in the same cycle as a decision still counts.
  assign w_pend_now     = w_sel_ok ? sel_req : r_pend;
  assign w_pend_vld_now = w_sel_ok | r_pend_vld;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_GUARD;
      r_gcnt     <= C_GLOAD;
      r_owner    <= C_ROWNER;
      r_pend     <= C_ROWNER;
      r_pend_vld <= 1'b0;
    end else begin
      case (r_state)
        S_OWNED: begin
          if (w_sel_ok && (sel_req != r_owner)) begin
            r_pend  <= sel_req;
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (w_sel_ok) begin
            r_pend <= sel_req;
          end
          if (w_own_csn) begin
            r_owner    <= w_pend_now;
            r_state    <= S_GUARD;
            r_gcnt     <= C_GLOAD;
            r_pend_vld <= 1'b0;
          end
        end
        S_GUARD: begin
          if (r_gcnt <= 8'd1) begin
            r_pend_vld <= 1'b0;
            if (w_pend_vld_now && (w_pend_now != r_owner)) begin
              r_pend  <= w_pend_now;
              r_state <= S_DRAIN;
            end else begin
              r_state <= S_OWNED;
            end
          end else begin
            r_gcnt <= r_gcnt - 8'd1;
            if (w_sel_ok) begin
              r_pend     <= sel_req;
              r_pend_vld <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= S_GUARD;
          r_gcnt  <= C_GLOAD;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Opcode snooper and abort control
  // --------------------------------------------------------------------------
  assign w_sck_rise = w_own_sck & ~r_sck_d;
  assign w_csn_edge = w_own_csn ^ r_csn_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_csn_d    <= 1'b1;
      r_sck_d    <= 1'b0;
      r_bitcnt   <= 4'd0;
      r_shift    <= 7'd0;
      r_cmd_byte <= 8'h00;
      r_cmd_stb  <= 1'b0;
      r_viol     <= 1'b0;
      r_force_cs <= 1'b0;
    end else begin
      r_cmd_stb <= 1'b0;
      r_viol    <= 1'b0;
      r_csn_d   <= w_own_csn;
      r_sck_d   <= w_own_sck;
      // Either CSN edge restarts the byte: a fall starts a transaction, a
      // rise discards any partial opcode and releases an abort.
      if (w_csn_edge) begin
        r_bitcnt   <= 4'd0;
        r_force_cs <= 1'b0;
      end else if (!w_own_csn && w_sck_rise && (r_bitcnt < 4'd8)) begin
        r_shift  <= {r_shift[5:0], w_own_mosi};
        r_bitcnt <= r_bitcnt + 4'd1;
        if (r_bitcnt == 4'd7) begin
          r_cmd_byte <= {r_shift, w_own_mosi};
          r_cmd_stb  <= 1'b1;
        end
      end
      // Abort only while CSN is steadily low, so a release can never be
      // overridden and leak a stale abort into the next transaction.
      if (r_cmd_stb && block_en && f_blocked(r_cmd_byte) &&
          !w_own_csn && !w_csn_edge) begin
        r_force_cs <= 1'b1;
        r_viol     <= 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign owner    = r_owner;
  assign sw_busy  = (r_state != S_OWNED);
  assign cmd_byte = r_cmd_byte;
  assign cmd_stb  = r_cmd_stb;
  assign viol     = r_viol;

endmodule
`default_nettype wire

// File: tb/tb_pfr_spi_mux.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_pfr_spi_mux
// Purpose  : Self-checking bench for pfr_spi_mux. Stimulus tasks push the
//            expected opcode / abort events into queues; a monitor pops and
//            compares them whenever the DUT strobes cmd_stb or viol.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pfr_spi_mux;
  localparam int N_HOST = 2;
  localparam int OWN_W  = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [N_HOST-1:0] hcsn, hsck, hmosi, hmiso;
  logic              fcsn, fsck, fmosi, fmiso;
  logic [OWN_W-1:0]  sel_req, owner;
  logic              sel_vld, block_en, sw_busy, cmd_stb, viol;
  logic [7:0]        cmd_byte;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] exp_cmd_q[$];
  logic [7:0] exp_viol_q[$];

  pfr_spi_mux #(
    .N_HOST(N_HOST), .OWN_W(OWN_W), .RESET_OWNER(0),
    .GUARD_CYC(4), .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .rst(rst),
    .hcsn(hcsn), .hsck(hsck), .hmosi(hmosi), .hmiso(hmiso),
    .fcsn(fcsn), .fsck(fsck), .fmosi(fmosi), .fmiso(fmiso),
    .sel_req(sel_req), .sel_vld(sel_vld), .block_en(block_en),
    .owner(owner), .sw_busy(sw_busy),
    .cmd_byte(cmd_byte), .cmd_stb(cmd_stb), .viol(viol)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference rules: the blocked opcode set and MISO fan-out.
  function automatic bit is_blocked(input logic [7:0] op);
    logic [7:0] lst [4];
    lst = '{8'h02, 8'h20, 8'h52, 8'hD8};
    foreach (lst[k]) if (lst[k] == op) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [N_HOST-1:0] exp_hmiso(input int own, input logic m);
    logic [N_HOST-1:0] v;
    v = '1;
    v[own] = m;
    return v;
  endfunction

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (cmd_stb) begin
        if (exp_cmd_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL cmd_stb: unexpected strobe with cmd_byte 0x%0h, none expected", cmd_byte);
        end else begin
          chk("cmd_byte", 32'(cmd_byte), 32'(exp_cmd_q.pop_front()));
        end
      end
      if (viol) begin
        if (exp_viol_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL viol: unexpected pulse with cmd_byte 0x%0h, none expected", cmd_byte);
        end else begin
          chk("viol_op", 32'(cmd_byte), 32'(exp_viol_q.pop_front()));
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic strobe(input int req);
    @(negedge clk); sel_req = OWN_W'(req); sel_vld = 1'b1;
    @(negedge clk); sel_vld = 1'b0;
  endtask

  // One SCK period = 4 CLK (2 low, 2 high); rising edge on a CLK negedge.
  task automatic send_bit(input int h, input logic b, input bit chk_cs, input logic exp_cs);
    logic m;
    @(negedge clk);
    hsck[h] = 1'b0; hmosi[h] = b;
    m = 1'($urandom_range(0, 1)); fmiso = m;
    #1;
    chk("fsck_lo", 32'(fsck), 32'(1'b0));
    chk("fmosi", 32'(fmosi), 32'(b));
    chk("hmiso", 32'(hmiso), 32'(exp_hmiso(h, m)));
    @(negedge clk);
    @(negedge clk);
    hsck[h] = 1'b1;
    #1;
    chk("fsck_hi", 32'(fsck), 32'(1'b1));
    if (chk_cs) chk("fcsn", 32'(fcsn), 32'(exp_cs));
    @(negedge clk);
  endtask

  task automatic xfer(input int h, input logic [7:0] op, input int nbits, input bit blk);
    bit hit;
    hit = blk && (nbits >= 8) && is_blocked(op);
    @(negedge clk);
    block_en = blk; hcsn[h] = 1'b0;
    if (nbits >= 8) exp_cmd_q.push_back(op);
    if (hit) exp_viol_q.push_back(op);
    @(negedge clk);
    for (int i = 0; i < nbits; i++)
      send_bit(h, (i < 8) ? op[7-i] : 1'($urandom_range(0, 1)),
               !(hit && i >= 8 && i < 12), hit && i >= 12);
    @(negedge clk); hsck[h] = 1'b0;
    tick(6);
    #1 chk("fcsn_hold", 32'(fcsn), 32'(hit));
    @(negedge clk); hcsn[h] = 1'b1;
    #1 chk("fcsn_end", 32'(fcsn), 32'(1'b1));
    tick(4);
  endtask

  task automatic rand_xfers(input int h, input int n);
    logic [7:0] ops [10];
    logic [7:0] op;
    int sel;
    ops = '{8'h02, 8'h20, 8'h52, 8'hD8, 8'h03, 8'h0B, 8'h06, 8'hC7, 8'h60, 8'h00};
    for (int t = 0; t < n; t++) begin
      sel = $urandom_range(0, 9);
      op  = (sel == 9) ? 8'($urandom) : ops[sel];
      xfer(h, op, $urandom_range(0, 40), 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic guard_check(input string tag, input int exp_owner);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk({tag, "_busy"}, 32'(sw_busy), 32'(1'b1));
      chk({tag, "_fcsn"}, 32'(fcsn), 32'(1'b1));
      chk({tag, "_fsck"}, 32'(fsck), 32'(1'b0));
      @(negedge clk);
    end
    #1;
    chk({tag, "_done"}, 32'(sw_busy), 32'(1'b0));
    chk({tag, "_owner"}, 32'(owner), 32'(exp_owner));
  endtask

  task automatic wait_idle(input int budget);
    int w;
    w = 0;
    while (sw_busy !== 1'b0 && w < budget) begin @(negedge clk); w++; end
    chk("idle_reached", 32'(sw_busy), 32'(1'b0));
  endtask

  task automatic wait_owner(input int exp_owner, input int budget);
    int w;
    w = 0;
    while (owner !== OWN_W'(exp_owner) && w < budget) begin @(negedge clk); w++; end
    chk("owner_reached", 32'(owner), 32'(exp_owner));
  endtask

  initial begin
    #500000;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    logic [7:0] op;
    hcsn = '1; hsck = '1; hmosi = '1; fmiso = 1'b0;
    sel_req = '0; sel_vld = 1'b0; block_en = 1'b0;

    // Reset state; host pins wiggling must not reach the flash in guard.
    tick(3);
    #1;
    chk("rst_fcsn", 32'(fcsn), 32'(1'b1));
    chk("rst_fsck", 32'(fsck), 32'(1'b0));
    chk("rst_fmosi", 32'(fmosi), 32'(1'b0));
    chk("rst_owner", 32'(owner), 32'(0));
    chk("rst_busy", 32'(sw_busy), 32'(1'b1));
    chk("rst_cmd", 32'(cmd_byte), 32'(8'h00));
    chk("rst_stb", 32'(cmd_stb), 32'(1'b0));
    chk("rst_viol", 32'(viol), 32'(1'b0));
    chk("rst_hmiso", 32'(hmiso), 32'(exp_hmiso(0, 1'b0)));
    @(negedge clk); rst = 1'b0;
    guard_check("init_guard", 0);
    chk("owned_fsck", 32'(fsck), 32'(1'b1));
    chk("owned_fmosi", 32'(fmosi), 32'(1'b1));
    @(negedge clk); hsck = '0; hmosi = '0;

    // Read passes, blocked erase aborted, next read passes.
    xfer(0, 8'h03, 32, 1'b1);
    xfer(0, 8'hD8, 32, 1'b1);
    xfer(0, 8'h03, 32, 1'b1);
    rand_xfers(0, 25);

    // Switch request mid-transaction on host0.
    op = 8'h03;
    @(negedge clk); block_en = 1'b0; hcsn[0] = 1'b0; exp_cmd_q.push_back(op);
    for (int i = 0; i < 8; i++) send_bit(0, op[7-i], 1'b1, 1'b0);
    strobe(1);
    #1 chk("mid_owner", 32'(owner), 32'(0));
    chk("mid_busy", 32'(sw_busy), 32'(1'b1));
    for (int i = 0; i < 8; i++) send_bit(0, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
    #1 chk("drain_owner", 32'(owner), 32'(0));
    @(negedge clk); hsck[0] = 1'b0; hsck[1] = 1'b1; hmosi[1] = 1'b1; hcsn[0] = 1'b1;
    wait_owner(1, 20);
    guard_check("sw_guard", 1);
    chk("sw_fsck", 32'(fsck), 32'(1'b1));
    chk("sw_fmosi", 32'(fmosi), 32'(1'b1));
    @(negedge clk); hsck[1] = 1'b0; hmosi[1] = 1'b0;
    xfer(1, 8'h0B, 24, 1'b0);
    xfer(1, 8'h20, 24, 1'b1);
    rand_xfers(1, 8);

    // Ignored requests while owned.
    strobe(5);
    #1 chk("oor_ignored", 32'(sw_busy), 32'(1'b0));
    strobe(1);
    #1 chk("same_ignored", 32'(sw_busy), 32'(1'b0));

    // Last in-range request in DRAIN wins (back to the current owner).
    @(negedge clk); hcsn[1] = 1'b0;
    tick(2);
    strobe(0);
    #1 chk("drain_enter", 32'(sw_busy), 32'(1'b1));
    strobe(1);
    strobe(5);
    @(negedge clk); hcsn[1] = 1'b1;
    wait_idle(40);
    chk("last_wins", 32'(owner), 32'(1));

    // Switch to host0, then a request latched during guard re-drains to 1.
    @(negedge clk); hcsn[1] = 1'b0;
    tick(2);
    strobe(0);
    strobe(5);
    @(negedge clk); hcsn[1] = 1'b1;
    wait_owner(0, 20);
    chk("guard_busy", 32'(sw_busy), 32'(1'b1));
    strobe(1);
    wait_idle(60);
    chk("guard_latch", 32'(owner), 32'(1));
    rand_xfers(1, 5);

    // Reset during the address phase of a host1 read.
    op = 8'h03;
    @(negedge clk); block_en = 1'b0; hcsn[1] = 1'b0; exp_cmd_q.push_back(op);
    for (int i = 0; i < 8; i++) send_bit(1, op[7-i], 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_fcsn", 32'(fcsn), 32'(1'b1));
    chk("arst_owner", 32'(owner), 32'(0));
    chk("arst_cmd", 32'(cmd_byte), 32'(8'h00));
    chk("arst_busy", 32'(sw_busy), 32'(1'b1));
    @(negedge clk); rst = 1'b0; hcsn[1] = 1'b1; hsck[1] = 1'b0;
    guard_check("arst_guard", 0);
    rand_xfers(0, 10);

    tick(5);
    chk("cmd_q_empty", 32'(exp_cmd_q.size()), 32'(0));
    chk("viol_q_empty", 32'(exp_viol_q.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
